// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and data load/store.
// Reads take LAT cycles and return data with a one-cycle valid pulse; writes complete in one cycle.
module mem_port_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int LAT    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] LAT_C = 4'(LAT);

   state_t            state_r;
   state_t            next_s;
   logic [3:0]        cnt_r;
   logic              last_d_r;
   logic              owner_d_r;
   logic              if_gnt_s;
   logic              d_gnt_s;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic [DATA_W-1:0] if_rdata_r;
   logic [DATA_W-1:0] d_rdata_r;

   // Next-state decode and IDLE arbitration; a tie goes to whoever was not served last.
   always_comb begin
      next_s   = state_r;
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (d_req && (!if_req || !last_d_r)) begin
               d_gnt_s = 1'b1;
               next_s  = d_we ? WR : RD;
            end else if (if_req) begin
               if_gnt_s = 1'b1;
               next_s   = RD;
            end else begin
               next_s = IDLE;
            end
         end
         RD: begin
            if (cnt_r == 4'd1) begin
               next_s = DONE;
            end else begin
               next_s = RD;
            end
         end
         WR:      next_s = IDLE;
         DONE:    next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Grant-time capture of the request, read countdown and read-data capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r       <= 4'd0;
         last_d_r    <= 1'b0;
         owner_d_r   <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
         if_rdata_r  <= {DATA_W{1'b0}};
         d_rdata_r   <= {DATA_W{1'b0}};
      end else if (d_gnt_s || if_gnt_s) begin
         owner_d_r  <= d_gnt_s;
         last_d_r   <= d_gnt_s;
         mem_addr_r <= d_gnt_s ? d_addr : if_addr;
         cnt_r      <= LAT_C;
         if (d_gnt_s) begin
            mem_wdata_r <= d_wdata;
         end
      end else if (state_r == RD) begin
         cnt_r <= cnt_r - 4'd1;
         // Memory data is valid in the last RD cycle; only the owner's register is updated.
         if (cnt_r == 4'd1) begin
            if (owner_d_r) begin
               d_rdata_r <= mem_rdata;
            end else begin
               if_rdata_r <= mem_rdata;
            end
         end
      end
   end

   assign if_gnt    = if_gnt_s & ~reset;
   assign d_gnt     = d_gnt_s & ~reset;
   assign if_valid  = (state_r == DONE) && !owner_d_r;
   assign d_valid   = ((state_r == DONE) && owner_d_r) || (state_r == WR);
   assign mem_wr    = (state_r == WR);
   assign busy      = (state_r != IDLE);
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a LAT=2 instance for most steps and a LAT=1 instance.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] if_addr = 64'h0, d_addr = 64'h0, d_wdata = 64'h0;
   logic        d_we = 1'b0;

   logic        if_req = 1'b0, d_req = 1'b0;
   logic [63:0] mem_rdata = 64'h0;
   logic        if_gnt, if_valid, d_gnt, d_valid, mem_wr, busy;
   logic [63:0] if_rdata, d_rdata, mem_addr, mem_wdata;

   logic        if_req1 = 1'b0, d_req1 = 1'b0;
   logic [63:0] mem_rdata1 = 64'h0;
   logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_wr1, busy1;
   logic [63:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(2)) u0 (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .LAT(1)) u1 (
      .clk(clk), .reset(reset),
      .if_req(if_req1), .if_addr(if_addr), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
      .d_req(d_req1), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_wr(mem_wr1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Advance n cycles, checking the grants are never both high.
   task automatic cycles_excl(input int n);
      for (int i = 0; i < n; i++) begin
         next();
         chk("gnt_exclusive", {63'h0, if_gnt & d_gnt}, 64'h0);
      end
   endtask

   initial begin
      // Reset state, with a fetch request held during reset
      if_req = 1'b1;
      next();
      next();
      chk("rst_if_gnt", {63'h0, if_gnt}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_valids", {62'h0, if_valid, d_valid}, 64'h0);
      chk("rst_mem_wr", {63'h0, mem_wr}, 64'h0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_if_rdata", if_rdata, 64'h0);
      chk("rst_d_rdata", d_rdata, 64'h0);
      if_req = 1'b0;
      reset  = 1'b0;
      next();

      // Fetch only, LAT=2: grant T, data captured at end of T+2, valid T+3
      if_req = 1'b1; if_addr = 64'h100; mem_rdata = 64'hBAD0;
      #1;
      chk("f_if_gnt", {63'h0, if_gnt}, 64'h1);
      chk("f_d_gnt", {63'h0, d_gnt}, 64'h0);
      next();
      if_req = 1'b0; if_addr = 64'h1FF; mem_rdata = 64'hBAD1;
      chk("f_addr_t1", mem_addr, 64'h100);
      chk("f_busy_t1", {63'h0, busy}, 64'h1);
      chk("f_mem_wr_t1", {63'h0, mem_wr}, 64'h0);
      next();
      mem_rdata = 64'h00A00093;
      chk("f_addr_t2", mem_addr, 64'h100);
      chk("f_valid_t2", {63'h0, if_valid}, 64'h0);
      next();
      mem_rdata = 64'hBAD2;
      chk("f_valid_t3", {63'h0, if_valid}, 64'h1);
      chk("f_rdata_t3", if_rdata, 64'h00A00093);
      chk("f_d_valid_t3", {63'h0, d_valid}, 64'h0);
      next();
      chk("f_busy_t4", {63'h0, busy}, 64'h0);
      chk("f_valid_t4", {63'h0, if_valid}, 64'h0);

      // Store: grant T, write strobe and d_valid at T+1 only
      d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD;
      #1;
      chk("s_d_gnt", {63'h0, d_gnt}, 64'h1);
      next();
      d_req = 1'b0; d_addr = 64'h999; d_wdata = 64'h1;
      chk("s_mem_wr", {63'h0, mem_wr}, 64'h1);
      chk("s_mem_addr", mem_addr, 64'h200);
      chk("s_mem_wdata", mem_wdata, 64'hDEAD);
      chk("s_d_valid", {63'h0, d_valid}, 64'h1);
      next();
      chk("s_busy_t2", {63'h0, busy}, 64'h0);
      chk("s_mem_wr_t2", {63'h0, mem_wr}, 64'h0);
      chk("s_d_valid_t2", {63'h0, d_valid}, 64'h0);
      d_we = 1'b0;

      // Simultaneous held requests after reset: data, fetch, data
      reset = 1'b1;
      next();
      reset = 1'b0;
      if_req = 1'b1; d_req = 1'b1; if_addr = 64'h300; d_addr = 64'h400; mem_rdata = 64'h11;
      #1;
      chk("tie1_d_gnt", {63'h0, d_gnt}, 64'h1);
      chk("tie1_if_gnt", {63'h0, if_gnt}, 64'h0);
      cycles_excl(3);
      chk("tie1_d_valid", {63'h0, d_valid}, 64'h1);
      chk("tie1_d_rdata", d_rdata, 64'h11);
      chk("tie1_no_if_gnt", {63'h0, if_gnt}, 64'h0);
      next();
      chk("tie2_if_gnt", {63'h0, if_gnt}, 64'h1);
      chk("tie2_d_gnt", {63'h0, d_gnt}, 64'h0);
      mem_rdata = 64'h22;
      cycles_excl(3);
      chk("tie2_if_valid", {63'h0, if_valid}, 64'h1);
      chk("tie2_if_rdata", if_rdata, 64'h22);
      chk("tie2_d_rdata_kept", d_rdata, 64'h11);
      next();
      chk("tie3_d_gnt", {63'h0, d_gnt}, 64'h1);
      chk("tie3_if_gnt", {63'h0, if_gnt}, 64'h0);
      chk("tie3_addr_pending", mem_addr, 64'h300);
      next();
      if_req = 1'b0; d_req = 1'b0;
      chk("tie3_mem_addr", mem_addr, 64'h400);
      next(); next(); next();
      chk("tie3_idle", {63'h0, busy}, 64'h0);

      // Data request raised while a fetch read is in progress
      if_req = 1'b1; if_addr = 64'h500;
      #1;
      chk("bz_if_gnt", {63'h0, if_gnt}, 64'h1);
      next();
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
      #1;
      chk("bz_d_gnt_t1", {63'h0, d_gnt}, 64'h0);
      next();
      d_addr = 64'h700;
      #1;
      chk("bz_d_gnt_t2", {63'h0, d_gnt}, 64'h0);
      next();
      d_addr = 64'h800;
      #1;
      chk("bz_d_gnt_t3", {63'h0, d_gnt}, 64'h0);
      next();
      chk("bz_d_gnt_t4", {63'h0, d_gnt}, 64'h1);
      next();
      d_req = 1'b0; mem_rdata = 64'h77;
      chk("bz_addr_t4", mem_addr, 64'h800);
      next(); next();
      chk("bz_d_valid", {63'h0, d_valid}, 64'h1);
      chk("bz_d_rdata", d_rdata, 64'h77);
      next();

      // Reset asserted in the middle of a fetch read
      if_req = 1'b1; if_addr = 64'h900; mem_rdata = 64'h55;
      #1;
      chk("rr_if_gnt", {63'h0, if_gnt}, 64'h1);
      next();
      if_req = 1'b0;
      next();
      reset = 1'b1;
      #1;
      chk("rr_busy", {63'h0, busy}, 64'h0);
      chk("rr_mem_addr", mem_addr, 64'h0);
      chk("rr_d_rdata", d_rdata, 64'h0);
      chk("rr_mem_wdata", mem_wdata, 64'h0);
      next();
      chk("rr_no_valid_a", {63'h0, if_valid}, 64'h0);
      chk("rr_if_rdata", if_rdata, 64'h0);
      reset = 1'b0;
      next();
      chk("rr_no_valid_b", {63'h0, if_valid}, 64'h0);
      next();
      chk("rr_no_valid_c", {63'h0, if_valid}, 64'h0);
      if_req = 1'b1; if_addr = 64'hA00; mem_rdata = 64'hCAFE;
      #1;
      chk("rr_new_gnt", {63'h0, if_gnt}, 64'h1);
      next();
      if_req = 1'b0;
      next(); next();
      chk("rr_new_valid", {63'h0, if_valid}, 64'h1);
      chk("rr_new_rdata", if_rdata, 64'hCAFE);
      next();

      // LAT=1 instance: grant T, valid T+2; a following load leaves if_rdata alone
      if_req1 = 1'b1; if_addr = 64'hB00; mem_rdata1 = 64'h1234;
      #1;
      chk("l1_if_gnt", {63'h0, if_gnt1}, 64'h1);
      next();
      if_req1 = 1'b0;
      chk("l1_busy_t1", {63'h0, busy1}, 64'h1);
      chk("l1_valid_t1", {63'h0, if_valid1}, 64'h0);
      next();
      chk("l1_valid_t2", {63'h0, if_valid1}, 64'h1);
      chk("l1_if_rdata", if_rdata1, 64'h1234);
      next();
      d_req1 = 1'b1; d_we = 1'b0; d_addr = 64'hC00; mem_rdata1 = 64'h5678;
      #1;
      chk("l1_d_gnt", {63'h0, d_gnt1}, 64'h1);
      next();
      d_req1 = 1'b0;
      chk("l1_mem_addr", mem_addr1, 64'hC00);
      next();
      chk("l1_d_valid", {63'h0, d_valid1}, 64'h1);
      chk("l1_d_rdata", d_rdata1, 64'h5678);
      chk("l1_if_rdata_kept", if_rdata1, 64'h1234);
      next();
      chk("l1_idle", {63'h0, busy1}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
